// File: rtl/apb_regfile_slave.sv
// APB completer with a byte register bank, a read-only write counter (WCNT)
// at the top address, configurable wait states and error response on bad accesses.
module apb_regfile_slave #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              i_pclk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_paddr,
  input  logic              i_pwrite,
  input  logic              i_psel,
  input  logic              i_penable,
  input  logic [DATA_W-1:0] i_pwdata,
  output logic [DATA_W-1:0] o_prdata,
  output logic              o_pready,
  output logic              o_pslverr
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err;
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_wcnt;

  logic              w_setup, w_step, w_done, w_abort, w_commit;
  logic              w_is_reg, w_is_wcnt, w_err;
  logic [DATA_W-1:0] w_rd;
  logic              w_pready_nxt, w_pslverr_nxt;
  logic [DATA_W-1:0] w_prdata_nxt;

  // Address decode and read mux for the setup phase
  always_comb begin
    w_is_reg = 1'b0;
    w_rd     = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (i_paddr == ADDR_W'(i)) begin
        w_is_reg = 1'b1;
        w_rd     = r_regs[i];
      end
    end
    w_is_wcnt = (i_paddr == {ADDR_W{1'b1}});
    if (w_is_wcnt) w_rd = r_wcnt;
    w_err = !(w_is_reg || w_is_wcnt) || (w_is_wcnt && i_pwrite);
  end

  assign w_setup  = (r_state == S_IDLE)   && i_psel && !i_penable;
  assign w_step   = (r_state == S_ACCESS) && i_psel && i_penable && (r_cnt != '0);
  assign w_done   = (r_state == S_ACCESS) && i_psel && i_penable && (r_cnt == '0);
  assign w_abort  = (r_state == S_ACCESS) && !i_psel;
  assign w_commit = w_done && r_write && !r_err;

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_setup)           w_state_nxt = S_ACCESS;
      S_ACCESS: if (w_done || w_abort) w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; pready/pslverr anticipate cnt reaching 0
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_pready_nxt  = o_pready;
    w_pslverr_nxt = o_pslverr;
    w_prdata_nxt  = o_prdata;
    if (w_setup) begin
      w_cnt_nxt     = CNT_W'(WAIT_CYCLES);
      w_pready_nxt  = (WAIT_CYCLES == 0);
      w_pslverr_nxt = w_err && (WAIT_CYCLES == 0);
      if (!i_pwrite) w_prdata_nxt = w_err ? '0 : w_rd;
    end else if (w_step) begin
      w_cnt_nxt     = r_cnt - CNT_W'(1);
      w_pready_nxt  = (r_cnt == CNT_W'(1));
      w_pslverr_nxt = r_err && (r_cnt == CNT_W'(1));
    end else if (w_done || w_abort) begin
      w_pready_nxt  = 1'b0;
      w_pslverr_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_err     <= 1'b0;
      r_wcnt    <= '0;
      o_prdata  <= '0;
      o_pready  <= 1'b0;
      o_pslverr <= 1'b0;
      for (int i = 0; i < int'(NUM_REGS); i++) r_regs[i] <= '0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      o_prdata  <= w_prdata_nxt;
      o_pready  <= w_pready_nxt;
      o_pslverr <= w_pslverr_nxt;
      if (w_setup) begin
        r_addr  <= i_paddr;
        r_write <= i_pwrite;
        r_wdata <= i_pwdata;
        r_err   <= w_err;
      end
      if (w_commit) begin
        for (int i = 0; i < int'(NUM_REGS); i++) begin
          if (r_addr == ADDR_W'(i)) r_regs[i] <= r_wdata;
        end
        r_wcnt <= r_wcnt + DATA_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Bench for apb_regfile_slave: zero-wait and 3-wait instances driven against a
// transaction-level model, checked every cycle plus literal spot checks.
module tb_apb_regfile_slave;

  localparam int unsigned NR = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] paddr;
  logic       pwrite;
  logic [7:0] pwdata;
  logic       psel    [2];
  logic       penable [2];
  logic [7:0] prdata  [2];
  logic       pready  [2];
  logic       pslverr [2];

  always #5 clk = ~clk;

  apb_regfile_slave #(.ADDR_W(4), .DATA_W(8), .NUM_REGS(NR), .WAIT_CYCLES(0)) u_dut0 (
    .i_pclk(clk), .i_rst_n(rst_n), .i_paddr(paddr), .i_pwrite(pwrite),
    .i_psel(psel[0]), .i_penable(penable[0]), .i_pwdata(pwdata),
    .o_prdata(prdata[0]), .o_pready(pready[0]), .o_pslverr(pslverr[0]));

  apb_regfile_slave #(.ADDR_W(4), .DATA_W(8), .NUM_REGS(NR), .WAIT_CYCLES(3)) u_dut3 (
    .i_pclk(clk), .i_rst_n(rst_n), .i_paddr(paddr), .i_pwrite(pwrite),
    .i_psel(psel[1]), .i_penable(penable[1]), .i_pwdata(pwdata),
    .o_prdata(prdata[1]), .o_pready(pready[1]), .o_pslverr(pslverr[1]));

  // Transaction-level model: register contents, counter, and expected outputs
  logic [7:0] m_regs [2][NR];
  logic [7:0] m_wcnt [2];
  logic [7:0] exp_prdata  [2];
  logic       exp_pready  [2];
  logic       exp_pslverr [2];
  bit         run = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic logic [7:0] m_read(input int k, input logic [3:0] a);
    if (a < 4'(NR))  return m_regs[k][a[2:0]];
    if (a == 4'hF)   return m_wcnt[k];
    return 8'h00;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < int'(NR); i++) m_regs[k][i] = 8'h00;
      m_wcnt[k]      = 8'h00;
      exp_prdata[k]  = 8'h00;
      exp_pready[k]  = 1'b0;
      exp_pslverr[k] = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (run) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("pready%0d", k),  8'(pready[k]),  8'(exp_pready[k]));
        check($sformatf("pslverr%0d", k), 8'(pslverr[k]), 8'(exp_pslverr[k]));
        check($sformatf("prdata%0d", k),  prdata[k],      exp_prdata[k]);
      end
    end
  end

  // One APB transfer; abort_at/rst_at name the access cycle (1-based) at which
  // psel is dropped or reset is asserted, 0 for none.
  task automatic xfer(input int k, input bit wr, input logic [3:0] a, input logic [7:0] d,
                      input int abort_at, input int rst_at, output bit got_err);
    bit e;
    int w;
    w = wait_of(k);
    e = !((a < 4'(NR)) || (a == 4'hF)) || (wr && (a == 4'hF));
    got_err = 1'b0;
    paddr = a; pwrite = wr; pwdata = d;
    psel[k] = 1'b1; penable[k] = 1'b0;
    tick();
    if (!wr) exp_prdata[k] = e ? 8'h00 : m_read(k, a);
    for (int i = 1; i <= w + 1; i++) begin
      exp_pready[k]  = (i == w + 1);
      exp_pslverr[k] = e && (i == w + 1);
      if (i == w + 1) got_err = pslverr[k];
      if (rst_at == i) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_mid_pready", 8'(pready[k]), 8'h00);
        check("rst_mid_prdata", prdata[k], 8'h00);
        psel[k] = 1'b0; penable[k] = 1'b0;
        tick();
        rst_n = 1'b1;
        return;
      end
      if (abort_at == i) begin
        psel[k] = 1'b0; penable[k] = 1'b0;
        tick();
        exp_pready[k] = 1'b0; exp_pslverr[k] = 1'b0;
        return;
      end
      penable[k] = 1'b1;
      paddr  = 4'($urandom);
      pwdata = 8'($urandom);
      tick();
    end
    exp_pready[k] = 1'b0; exp_pslverr[k] = 1'b0;
    if (wr && !e) begin
      m_regs[k][a[2:0]] = d;
      m_wcnt[k]         = m_wcnt[k] + 8'd1;
    end
    psel[k] = 1'b0; penable[k] = 1'b0;
  endtask

  task automatic wr(input int k, input logic [3:0] a, input logic [7:0] d);
    bit e;
    xfer(k, 1'b1, a, d, 0, 0, e);
  endtask

  task automatic rd_expect(input int k, input logic [3:0] a, input logic [7:0] lit, input string nm);
    bit e;
    xfer(k, 1'b0, a, 8'h00, 0, 0, e);
    check(nm, prdata[k], lit);
  endtask

  initial begin
    bit e;
    rst_n = 1'b0; paddr = '0; pwrite = 1'b0; pwdata = '0;
    for (int k = 0; k < 2; k++) begin psel[k] = 1'b0; penable[k] = 1'b0; end
    model_reset();
    run = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    check("reset_prdata", prdata[1], 8'h00);
    check("reset_pready", 8'(pready[1]), 8'h00);

    // Back-to-back writes and reads on both latencies
    for (int k = 0; k < 2; k++) begin
      wr(k, 4'd2, 8'd5); wr(k, 4'd3, 8'd10); wr(k, 4'd4, 8'd5); wr(k, 4'd5, 8'd10);
      rd_expect(k, 4'd2, 8'd5,  "rd2");
      rd_expect(k, 4'd3, 8'd10, "rd3");
      rd_expect(k, 4'd4, 8'd5,  "rd4");
      rd_expect(k, 4'd5, 8'd10, "rd5");
      rd_expect(k, 4'hF, 8'd4,  "wcnt4");
    end

    // Unmapped and read-only accesses
    xfer(1, 1'b1, 4'd9, 8'hAA, 0, 0, e);  check("err_wr9", 8'(e), 8'h01);
    xfer(1, 1'b0, 4'd9, 8'h00, 0, 0, e);  check("err_rd9", 8'(e), 8'h01);
    check("rd9_data", prdata[1], 8'h00);
    xfer(1, 1'b1, 4'hF, 8'h12, 0, 0, e);  check("err_wrF", 8'(e), 8'h01);
    rd_expect(1, 4'hF, 8'd4, "wcnt_after_err");
    xfer(1, 1'b0, 4'd2, 8'h00, 0, 0, e);  check("ok_rd2", 8'(e), 8'h00);

    // Abort after first access cycle, then a normal transfer
    xfer(1, 1'b1, 4'd1, 8'h33, 1, 0, e);
    rd_expect(1, 4'd1, 8'h00, "abort_rd1");
    rd_expect(1, 4'hF, 8'd4,  "abort_wcnt");
    wr(1, 4'd1, 8'h33);
    rd_expect(1, 4'd1, 8'h33, "after_abort_rd1");

    // Reset during a write access phase
    rd_expect(1, 4'd2, 8'd5, "pre_rst_rd2");
    xfer(1, 1'b1, 4'd6, 8'h77, 0, 1, e);
    rd_expect(1, 4'd6, 8'h00, "post_rst_rd6");
    rd_expect(1, 4'hF, 8'h00, "post_rst_wcnt");

    // Counter wrap after 256 successful writes
    for (int i = 0; i < 256; i++) wr(0, 4'(i % 8), 8'($urandom));
    rd_expect(0, 4'hF, 8'h00, "wcnt_wrap");

    // prdata survives a following write
    wr(0, 4'd3, 8'h5A);
    rd_expect(0, 4'd3, 8'h5A, "rd3_5a");
    wr(0, 4'd4, 8'hC3);
    check("prdata_hold", prdata[0], 8'h5A);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int k;
      int ab;
      k  = int'($urandom_range(0, 1));
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, wait_of(k) + 1)) : 0;
      xfer(k, 1'($urandom), 4'($urandom), 8'($urandom), ab, 0, e);
      if ($urandom_range(0, 3) == 0) tick();
    end
    for (int k = 0; k < 2; k++) begin
      xfer(k, 1'b0, 4'hF, 8'h00, 0, 0, e);
      check("final_wcnt", prdata[k], m_wcnt[k]);
    end

    tick();
    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
